// File: rtl/avmm_flash_responder.sv
// Avalon-MM pipelined-read responder standing in for the external instruction flash.
// On-chip word array with programmable wait states, read latency and read-outstanding limit.
module avmm_flash_responder #(
    parameter int MEM_WORDS    = 16384,
    parameter int WAIT_STATES  = 2,
    parameter int READ_LATENCY = 3,
    parameter int MAX_PENDING  = 4,
    parameter bit SWAP_BYTES   = 1'b1
) (
    input  logic        IO_CLK,
    input  logic        IO_RST,
    input  logic [31:0] avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [3:0]  avs_byteenable,
    input  logic [31:0] avs_writedata,
    input  logic        avs_burstcount,
    output logic        avs_waitrequest,
    output logic [31:0] avs_readdata,
    output logic        avs_readdatavalid,
    output logic [2:0]  pending_o,
    output logic        err_o
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int WW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam int PW = $clog2(MAX_PENDING + 1);
    localparam logic [31:0] BAD_DATA = 32'hBADCAB1E;

    logic [31:0]   mem [MEM_WORDS];
    logic [WW-1:0] wait_cnt;
    logic [PW-1:0] pending;
    logic          cmd, wait_done, pend_ok, accept, acc_rd, acc_wr, oor, bad_cmd;
    logic [AW-1:0] idx;
    logic [31:0]   mem_word, rd_word, last_dat;
    logic          last_vld;

    assign cmd       = avs_read | avs_write;
    assign oor       = (avs_address >= 32'(MEM_WORDS));
    assign idx       = avs_address[AW-1:0];
    assign wait_done = (wait_cnt == WW'(WAIT_STATES));
    // A response leaving this cycle frees its slot for a read accepted in the same cycle.
    assign pend_ok   = (pending < PW'(MAX_PENDING)) | avs_readdatavalid;
    assign accept    = ~IO_RST & cmd & wait_done & (~avs_read | pend_ok);
    assign acc_rd    = accept & avs_read;
    assign acc_wr    = accept & avs_write & ~avs_read & ~oor;
    assign bad_cmd   = (avs_read & avs_write) | ~avs_burstcount | oor;

    assign avs_waitrequest = ~accept;
    assign pending_o       = 3'(pending);

    assign mem_word = mem[idx];
    assign rd_word  = oor        ? BAD_DATA :
                      SWAP_BYTES ? {mem_word[7:0], mem_word[15:8], mem_word[23:16], mem_word[31:24]} :
                                   mem_word;

    // Array has no reset so its contents survive IO_RST.
    always_ff @(posedge IO_CLK) begin
        if (acc_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (avs_byteenable[i]) begin
                    if (SWAP_BYTES) mem[idx][8*(3-i) +: 8] <= avs_writedata[8*i +: 8];
                    else            mem[idx][8*i +: 8]     <= avs_writedata[8*i +: 8];
                end
            end
        end
    end

    generate
        if (READ_LATENCY == 1) begin : g_direct
            assign last_vld = acc_rd;
            assign last_dat = rd_word;
        end else begin : g_pipe
            logic [READ_LATENCY-2:0]       vld_pipe;
            logic [READ_LATENCY-2:0][31:0] dat_pipe;
            always_ff @(posedge IO_CLK or posedge IO_RST) begin
                if (IO_RST) begin
                    vld_pipe <= '0;
                    dat_pipe <= '0;
                end else begin
                    vld_pipe[0] <= acc_rd;
                    dat_pipe[0] <= rd_word;
                    for (int s = 1; s < READ_LATENCY - 1; s++) begin
                        vld_pipe[s] <= vld_pipe[s-1];
                        dat_pipe[s] <= dat_pipe[s-1];
                    end
                end
            end
            assign last_vld = vld_pipe[READ_LATENCY-2];
            assign last_dat = dat_pipe[READ_LATENCY-2];
        end
    endgenerate

    always_ff @(posedge IO_CLK or posedge IO_RST) begin
        if (IO_RST) begin
            avs_readdatavalid <= 1'b0;
            avs_readdata      <= '0;
            wait_cnt          <= '0;
            pending           <= '0;
            err_o             <= 1'b0;
        end else begin
            avs_readdatavalid <= last_vld;
            if (last_vld) avs_readdata <= last_dat;

            if (!cmd || accept)  wait_cnt <= '0;
            else if (!wait_done) wait_cnt <= wait_cnt + WW'(1);

            if (acc_rd && !avs_readdatavalid)      pending <= pending + PW'(1);
            else if (!acc_rd && avs_readdatavalid) pending <= pending - PW'(1);

            if (accept && bad_cmd) err_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_avmm_flash_responder.sv
// Bench for avmm_flash_responder: default-parameter instance checked against a queue-based
// model, plus a zero-wait / two-deep instance for backpressure and in-flight reset.
module tb_avmm_flash_responder;
    localparam int WS = 2, RL = 3, MP = 4, MW = 16384;

    logic IO_CLK = 1'b0;
    logic IO_RST = 1'b1;
    always #5 IO_CLK = ~IO_CLK;

    logic [31:0] a_addr = '0, a_wdata = '0, a_rdata;
    logic        a_rd = 1'b0, a_wr = 1'b0, a_bc = 1'b1, a_wreq, a_vld, a_err;
    logic [3:0]  a_be = '0;
    logic [2:0]  a_pend;

    logic [31:0] b_addr = '0, b_wdata = '0, b_rdata;
    logic        b_rd = 1'b0, b_wr = 1'b0, b_bc = 1'b1, b_wreq, b_vld, b_err;
    logic [3:0]  b_be = '0;
    logic [2:0]  b_pend;

    int checks = 0, errors = 0;

    avmm_flash_responder dut_a (
        .IO_CLK(IO_CLK), .IO_RST(IO_RST), .avs_address(a_addr), .avs_read(a_rd),
        .avs_write(a_wr), .avs_byteenable(a_be), .avs_writedata(a_wdata),
        .avs_burstcount(a_bc), .avs_waitrequest(a_wreq), .avs_readdata(a_rdata),
        .avs_readdatavalid(a_vld), .pending_o(a_pend), .err_o(a_err));

    avmm_flash_responder #(.MEM_WORDS(MW), .WAIT_STATES(0), .READ_LATENCY(3),
                           .MAX_PENDING(2), .SWAP_BYTES(1'b1)) dut_b (
        .IO_CLK(IO_CLK), .IO_RST(IO_RST), .avs_address(b_addr), .avs_read(b_rd),
        .avs_write(b_wr), .avs_byteenable(b_be), .avs_writedata(b_wdata),
        .avs_burstcount(b_bc), .avs_waitrequest(b_wreq), .avs_readdata(b_rdata),
        .avs_readdatavalid(b_vld), .pending_o(b_pend), .err_o(b_err));

    // Model of dut_a: words kept in bus byte order, responses as (return cycle, data).
    typedef struct { int cyc; logic [31:0] data; } ret_t;
    ret_t        ret_q[$];
    logic [31:0] m_mem [int];
    int          m_cyc = 0, m_waited = 0;
    logic        m_err = 1'b0;
    logic [31:0] m_last = '0;
    logic        e_vld, e_acc, e_wreq;
    int          e_pend;
    logic [31:0] e_rdata;

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a >= MW) return 32'hBADCAB1E;
        return m_mem[int'(a)];
    endfunction

    task automatic mdl_eval();
        int inflight;
        e_vld    = (ret_q.size() > 0) && (ret_q[0].cyc == m_cyc);
        inflight = ret_q.size() - (e_vld ? 1 : 0);
        e_acc    = (a_rd || a_wr) && (m_waited >= WS) && (!a_rd || inflight < MP);
        e_wreq   = !e_acc;
        e_pend   = ret_q.size();
        e_rdata  = e_vld ? ret_q[0].data : m_last;
    endtask

    task automatic mdl_commit();
        ret_t        r;
        logic [31:0] w;
        if (e_vld) begin
            m_last = ret_q[0].data;
            void'(ret_q.pop_front());
        end
        if (e_acc) begin
            if (a_rd) begin
                r.cyc  = m_cyc + RL;
                r.data = m_read(a_addr);
                ret_q.push_back(r);
            end else if (a_addr < MW) begin
                w = m_mem.exists(int'(a_addr)) ? m_mem[int'(a_addr)] : 32'h0;
                for (int i = 0; i < 4; i++) if (a_be[i]) w[8*i +: 8] = a_wdata[8*i +: 8];
                m_mem[int'(a_addr)] = w;
            end
            if ((a_rd && a_wr) || !a_bc || a_addr >= MW) m_err = 1'b1;
            m_waited = 0;
        end else if (a_rd || a_wr) m_waited++;
        else m_waited = 0;
        m_cyc++;
    endtask

    task automatic mdl_reset();
        ret_q.delete();
        m_waited = 0;
        m_err    = 1'b0;
        m_last   = '0;
    endtask

    task automatic set_a(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] d, input logic bc);
        a_rd = rd; a_wr = wr; a_addr = addr; a_be = be; a_wdata = d; a_bc = bc;
    endtask

    task automatic set_b(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] d);
        b_rd = rd; b_wr = wr; b_addr = addr; b_be = be; b_wdata = d;
    endtask

    task automatic adv();
        mdl_eval();
        @(posedge IO_CLK);
        if (!IO_RST) mdl_commit();
        #1;
    endtask

    // Stimulus only: present a command on dut_a until the model accepts it.
    task automatic issue_a(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] d, input logic bc);
        logic acc;
        acc = 1'b0;
        set_a(rd, wr, addr, be, d, bc);
        for (int c = 0; c < 20 && !acc; c++) begin
            adv();
            acc = e_acc;
        end
        set_a(1'b0, 1'b0, '0, '0, '0, 1'b1);
    endtask

    // Observation only: count valid pulses and keep the last returned word.
    task automatic drain_a(input int n, output int cnt, output logic [31:0] last);
        cnt  = 0;
        last = '0;
        for (int c = 0; c < n; c++) begin
            @(negedge IO_CLK);
            if (a_vld) begin cnt++; last = a_rdata; end
            adv();
        end
    endtask

    task automatic do_reset();
        IO_RST = 1'b1;
        #1;
        mdl_reset();
        @(posedge IO_CLK);
        #1;
        IO_RST = 1'b0;
    endtask

    task automatic test_reset();
        b_rd = 1'b1;
        #3;
        checks++;
        if ({a_wreq, a_vld, a_pend, a_err} !== {1'b1, 1'b0, 3'd0, 1'b0} || a_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_a: wreq/vld/pend/err=%b/%b/%0d/%b rdata=%h required 1/0/0/0 00000000",
                     a_wreq, a_vld, a_pend, a_err, a_rdata);
        end
        checks++;
        if (b_wreq !== 1'b1 || b_vld !== 1'b0 || b_pend !== 3'd0) begin
            errors++;
            $display("FAIL reset_b_cmd_held: wreq/vld/pend=%b/%b/%0d required 1/0/0", b_wreq, b_vld, b_pend);
        end
        @(posedge IO_CLK);
        #1;
        b_rd   = 1'b0;
        IO_RST = 1'b0;
        mdl_reset();
    endtask

    task automatic test_read_timing();
        issue_a(1'b0, 1'b1, 32'd5, 4'hF, 32'h44332211, 1'b1);
        checks++;
        if (dut_a.mem[5] !== 32'h11223344) begin
            errors++;
            $display("FAIL stored_byte_order: mem[5]=%h required 11223344", dut_a.mem[5]);
        end
        set_a(1'b1, 1'b0, 32'd5, 4'h0, '0, 1'b1);
        for (int c = 0; c < 7; c++) begin
            @(negedge IO_CLK);
            checks++;
            if (a_wreq !== (c != 2)) begin
                errors++;
                $display("FAIL read_waitrequest cycle %0d: got %b required %b", c, a_wreq, c != 2);
            end
            checks++;
            if (a_vld !== (c == 5) || (c == 5 && a_rdata !== 32'h44332211)) begin
                errors++;
                $display("FAIL read_valid cycle %0d: vld=%b data=%h required vld=%b data=44332211",
                         c, a_vld, a_rdata, c == 5);
            end
            adv();
            if (c == 2) set_a(1'b0, 1'b0, '0, '0, '0, 1'b1);
        end
    endtask

    task automatic test_partial_write();
        int          cnt;
        logic [31:0] d;
        issue_a(1'b0, 1'b1, 32'd7, 4'hF, 32'h0, 1'b1);
        issue_a(1'b0, 1'b1, 32'd7, 4'b0011, 32'hAABBCCDD, 1'b1);
        issue_a(1'b1, 1'b0, 32'd7, 4'h0, '0, 1'b1);
        drain_a(6, cnt, d);
        checks++;
        if (cnt != 1 || d !== 32'h0000CCDD || a_err !== 1'b0) begin
            errors++;
            $display("FAIL partial_write: pulses=%0d data=%h err=%b required 1 0000CCDD 0", cnt, d, a_err);
        end
    endtask

    task automatic test_backpressure();
        int          q[$];
        logic        v, acc;
        logic [31:0] val;
        val = $urandom;
        set_b(1'b0, 1'b1, 32'd3, 4'hF, val);
        @(negedge IO_CLK);
        checks++;
        if (b_wreq !== 1'b0) begin
            errors++;
            $display("FAIL b_zero_wait_write: wreq=%b required 0", b_wreq);
        end
        adv();
        for (int c = 0; c < 14; c++) begin
            set_b(c < 9, 1'b0, 32'd3, 4'h0, '0);
            @(negedge IO_CLK);
            v   = (q.size() > 0) && (q[0] == c);
            acc = b_rd && ((q.size() - (v ? 1 : 0)) < 2);
            checks++;
            if (b_wreq !== !acc || b_vld !== v || b_pend !== 3'(q.size()) || b_pend > 3'd2 ||
                (v && b_rdata !== val)) begin
                errors++;
                $display("FAIL backpressure cycle %0d: wreq/vld/pend=%b/%b/%0d data=%h required %b/%b/%0d %h",
                         c, b_wreq, b_vld, b_pend, b_rdata, !acc, v, q.size(), val);
            end
            adv();
            if (v) void'(q.pop_front());
            if (acc) q.push_back(c + 3);
        end
        set_b(1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic test_out_of_range();
        int          cnt;
        logic [31:0] d;
        do_reset();
        issue_a(1'b1, 1'b0, 32'd16384, 4'h0, '0, 1'b1);
        drain_a(6, cnt, d);
        checks++;
        if (cnt != 1 || d !== 32'hBADCAB1E || a_err !== 1'b1) begin
            errors++;
            $display("FAIL oor_read: pulses=%0d data=%h err=%b required 1 BADCAB1E 1", cnt, d, a_err);
        end
        issue_a(1'b0, 1'b1, 32'd16389, 4'hF, 32'h0, 1'b1);
        issue_a(1'b1, 1'b0, 32'd5, 4'h0, '0, 1'b1);
        drain_a(6, cnt, d);
        checks++;
        if (cnt != 1 || d !== 32'h44332211 || a_err !== 1'b1) begin
            errors++;
            $display("FAIL after_oor_read5: pulses=%0d data=%h err=%b required 1 44332211 1", cnt, d, a_err);
        end
    endtask

    task automatic test_error_cmds();
        int          cnt;
        logic [31:0] d;
        do_reset();
        checks++;
        if (a_err !== 1'b0) begin
            errors++;
            $display("FAIL err_cleared_by_reset: err=%b required 0", a_err);
        end
        issue_a(1'b1, 1'b1, 32'd5, 4'hF, 32'hDEADBEEF, 1'b1);
        drain_a(6, cnt, d);
        checks++;
        if (cnt != 1 || d !== 32'h44332211 || a_err !== 1'b1) begin
            errors++;
            $display("FAIL read_write_both: pulses=%0d data=%h err=%b required 1 44332211 1", cnt, d, a_err);
        end
        do_reset();
        issue_a(1'b1, 1'b0, 32'd5, 4'h0, '0, 1'b0);
        drain_a(6, cnt, d);
        checks++;
        if (cnt != 1 || d !== 32'h44332211 || a_err !== 1'b1) begin
            errors++;
            $display("FAIL burstcount_zero: pulses=%0d data=%h err=%b required 1 44332211 1", cnt, d, a_err);
        end
    endtask

    task automatic test_random();
        int   ops, idle_left, k, cyc;
        logic busy, acc, rd, wr;
        logic [31:0] addr;
        for (int w = 0; w < 16; w++) issue_a(1'b0, 1'b1, 32'(w), 4'hF, $urandom, 1'b1);
        ops = 0; idle_left = 0; busy = 1'b0; cyc = 0;
        while (cyc < 1000 && (busy || ops < 80 || ret_q.size() > 0)) begin
            if (!busy && idle_left == 0 && ops < 80) begin
                k    = $urandom_range(0, 9);
                addr = (k == 0) ? 32'(MW + $urandom_range(0, 7)) : 32'($urandom_range(0, 15));
                rd   = (k < 5) || (k == 9);
                wr   = (k >= 5);
                set_a(rd, wr, addr, 4'($urandom), $urandom, $urandom_range(0, 7) != 0);
                busy = 1'b1;
                ops++;
            end
            @(negedge IO_CLK);
            mdl_eval();
            checks++;
            if (a_wreq !== e_wreq || a_vld !== e_vld || a_pend !== 3'(e_pend) ||
                a_rdata !== e_rdata || a_err !== m_err) begin
                errors++;
                $display("FAIL random cycle %0d: wreq/vld/pend/err=%b/%b/%0d/%b data=%h required %b/%b/%0d/%b %h",
                         cyc, a_wreq, a_vld, a_pend, a_err, a_rdata, e_wreq, e_vld, e_pend, m_err, e_rdata);
            end
            acc = e_acc;
            adv();
            if (busy && acc) begin
                busy = 1'b0;
                set_a(1'b0, 1'b0, '0, '0, '0, 1'b1);
                idle_left = $urandom_range(0, 2);
            end else if (!busy && idle_left > 0) idle_left--;
            cyc++;
        end
        checks++;
        if (busy || ops < 80 || ret_q.size() != 0) begin
            errors++;
            $display("FAIL random_timeout: ops=%0d busy=%b outstanding=%0d required 80 0 0", ops, busy, ret_q.size());
        end
    endtask

    task automatic test_reset_inflight();
        int          cnt;
        logic [31:0] d, exp5;
        set_b(1'b1, 1'b0, 32'd3, 4'h0, '0);
        adv();
        adv();
        set_b(1'b0, 1'b0, '0, '0, '0);
        adv();
        checks++;
        if (b_vld !== 1'b1 || b_pend !== 3'd2) begin
            errors++;
            $display("FAIL inflight_before_reset: vld=%b pend=%0d required 1 2", b_vld, b_pend);
        end
        IO_RST = 1'b1;
        #1;
        mdl_reset();
        checks++;
        if (b_vld !== 1'b0 || b_pend !== 3'd0 || b_wreq !== 1'b1 || a_pend !== 3'd0) begin
            errors++;
            $display("FAIL async_reset: vld=%b pend=%0d wreq=%b a_pend=%0d required 0 0 1 0",
                     b_vld, b_pend, b_wreq, a_pend);
        end
        @(posedge IO_CLK);
        #1;
        IO_RST = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge IO_CLK);
            checks++;
            if (b_vld !== 1'b0 || b_pend !== 3'd0) begin
                errors++;
                $display("FAIL stale_after_reset cycle %0d: vld=%b pend=%0d required 0 0", c, b_vld, b_pend);
            end
            adv();
        end
        exp5 = m_read(32'd5);
        issue_a(1'b1, 1'b0, 32'd5, 4'h0, '0, 1'b1);
        drain_a(6, cnt, d);
        checks++;
        if (cnt != 1 || d !== exp5) begin
            errors++;
            $display("FAIL word_kept_over_reset: pulses=%0d data=%h required 1 %h", cnt, d, exp5);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_read_timing();
        test_partial_write();
        test_backpressure();
        test_out_of_range();
        test_error_cmds();
        test_random();
        test_reset_inflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/avmm_flash_responder.md
Name: avmm_flash_responder

Overview:
- Avalon-MM pipelined-read slave that models the external-flash instruction ROM, with configurable wait states and read latency.
- Backed by an on-chip word array.
- Lets the core's fetch path (sampled read/address, waitrequest, readdatavalid) run in simulation and in flash-less FPGA builds, without the EPCQ controller.
- Sits at the responder end of the ROM interface, in place of the flash controller's rom_if.

Parameters:
- MEM_WORDS, 16384, number of 32-bit words stored; power of two.
- WAIT_STATES, 2, cycles waitrequest stays high before a presented command is accepted (0 allowed).
- READ_LATENCY, 3, clock edges from read acceptance to the readdatavalid cycle (min 1).
- MAX_PENDING, 4, maximum accepted-but-unreturned reads (min 1).
- SWAP_BYTES, 1, 1 = byte order reversed on both read return and write store (flash byte order).

Ports:
- IO_CLK  in  1  clock.
- IO_RST  in  1  asynchronous active-high reset.
- avs_address  in  32  word address.
- avs_read  in  1  read command.
- avs_write  in  1  write command.
- avs_byteenable  in  4  write byte enables.
- avs_writedata  in  32  write data.
- avs_burstcount  in  1  burst length; only 1 is legal.
- avs_waitrequest  out  1  command not accepted this cycle.
- avs_readdata  out  32  read data.
- avs_readdatavalid  out  1  read data valid, one pulse per accepted read.
- pending_o  out  3  outstanding read count.
- err_o  out  1  sticky protocol/address error.

Behaviour:
- Reset (async, active-high):
  - avs_waitrequest=1, avs_readdatavalid=0, avs_readdata=0, pending_o=0, err_o=0, wait counter=0.
  - Latency pipeline cleared; in-flight reads are discarded and never return.
  - Array contents are not reset.
- Command present (cmd) = avs_read | avs_write.
- Wait counter:
  - Increments each cycle cmd is high and not accepted, saturating at WAIT_STATES.
  - Clears on acceptance or when cmd drops.
- accept = cmd & (wait_cnt==WAIT_STATES) & (avs_write_only | pending<MAX_PENDING).
  - avs_waitrequest = ~accept, combinational from registered state and inputs.
  - Waitrequest is high whenever idle.
  - The master holds the command stable while waitrequest is high.
- Read and write asserted together:
  - err_o set; the command is treated as a read and the write is ignored.
- avs_burstcount != 1:
  - err_o set; the command is treated as a single transfer.
- Address range:
  - index = avs_address[log2(MEM_WORDS)-1:0].
  - avs_address >= MEM_WORDS: err_o set, write dropped, read returns 32'hBADCAB1E.
- Write:
  - Takes effect at the accepting edge; byte lanes merge per avs_byteenable.
  - With SWAP_BYTES=1, writedata byte i is stored to byte 3-i.
  - byteenable is applied in bus lane order: be[i] gates stored byte 3-i.
- Read:
  - Array is sampled at the accepting edge (read-after-write to the same word in the prior accept returns new data).
  - Data enters a READ_LATENCY-deep pipeline.
  - avs_readdatavalid is high in the cycle following edge acc+READ_LATENCY-1 (READ_LATENCY=1 gives valid the cycle after acceptance).
  - Responses are in order; back-to-back accepted reads give back-to-back valid pulses.
  - avs_readdata holds its last value while valid is low.
- pending_o:
  - +1 on read accept, -1 on a valid cycle; unchanged when both happen in the same cycle.
  - Never exceeds MAX_PENDING.
  - While pending==MAX_PENDING, read commands wait and writes still proceed.
- err_o clears only on reset.

Test Plan:
1. WAIT_STATES=2, READ_LATENCY=3, word 5 preloaded 32'h11223344. Read addr 5 held from cycle 0:
   - waitrequest high in cycles 0–1, low in cycle 2.
   - readdatavalid in cycle 5 with readdata 32'h44332211 (SWAP_BYTES=1).
2. Write addr 7 data 32'hAABBCCDD be=4'b0011 over word 32'h0. Then read addr 7:
   - Returns 32'h0000CCDD when swapped back, i.e. readdata 32'h0000CCDD.
   - err_o stays 0.
3. WAIT_STATES=0, MAX_PENDING=2, READ_LATENCY=3. Read held continuously:
   - Accepts in cycles 0 and 1; waitrequest high in cycle 2.
   - Re-accepts in cycle 3 as the first valid returns.
   - pending_o never exceeds 2.
4. Read addr 16384:
   - Returns 32'hBADCAB1E; err_o=1 and stays 1.
   - A following read of addr 5 returns correct data.
5. avs_read and avs_write high together, then burstcount=0:
   - err_o=1; exactly one readdatavalid per command; memory unchanged.
6. Assert IO_RST with 2 reads in flight:
   - readdatavalid=0 and pending_o=0 immediately (asynchronously).
   - No stale valid after deassert; previously written words intact.
